eth_rx_frame_parser: RTL and testbench

- Consumes the speed-normalised GMII byte stream (e_rx_dv/e_rxd) produced by the speed arbiter, at the byte rate of clk.
- Strips preamble/SFD, filters on destination MAC, extracts the source MAC and ethertype, and checks CRC32 and frame length.
- Emits the payload with FCS removed, plus a per-frame good/bad verdict. The downstream FIFO commits or rolls back on that verdict.

---
 rtl/eth_pkg.sv | 23 ++
 rtl/eth_crc32_d8.sv | 25 ++
 rtl/eth_rx_frame_parser.sv | 183 ++++++++++++++++++
 tb/tb_eth_rx_frame_parser.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: framing constants, CRC32 constants and the
// receive parser state encoding.
package eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
  localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;
  localparam int          HDR_BYTES     = 14;
  localparam int          FCS_BYTES     = 4;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    HDR,
    PAY,
    END,
    DROP
  } rx_state_t;

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational one-byte step of the reflected (LSB-first) CRC32 used for the
// Ethernet FCS; shared by the receive checker and the transmit generator.
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ CRC_POLY_REFL;
      end else begin
        c = c >> 1;
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_rx_frame_parser.sv
// GMII receive parser: strips preamble/SFD, filters on destination MAC,
// extracts header fields, strips the FCS and issues a per-frame verdict.
module eth_rx_frame_parser
  import eth_pkg::*;
#(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518,
  parameter bit CHECK_MAC = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_dv,
  input  logic [7:0]  rxd,
  input  logic [47:0] local_mac,
  output logic        payload_valid,
  output logic [7:0]  payload_data,
  output logic        payload_sof,
  output logic        payload_eof,
  output logic        frame_done,
  output logic        frame_good,
  output logic [47:0] src_mac,
  output logic [15:0] eth_type,
  output logic [15:0] good_cnt,
  output logic [15:0] err_cnt
);

  localparam logic [10:0] LEN_SAT   = 11'(MAX_FRAME + 1);
  localparam logic [10:0] LEN_MIN   = 11'(MIN_FRAME);
  localparam logic [10:0] LEN_MAX   = 11'(MAX_FRAME);
  localparam logic [10:0] DEST_LAST = 11'd5;
  localparam logic [10:0] HDR_LAST  = 11'(HDR_BYTES - 1);
  localparam logic [2:0]  LINE_FULL = 3'(FCS_BYTES);

  rx_state_t                   state_reg;
  logic [2:0]                  pre_cnt_reg;
  logic [10:0]                 len_reg;
  logic [31:0]                 crc_reg;
  logic [55:0]                 hdr_sr_reg;
  logic [FCS_BYTES-1:0][7:0]   dline_reg;
  logic [2:0]                  dfill_reg;
  logic                        sof_pend_reg;

  logic [31:0] crc_next;
  logic [10:0] len_next;
  logic [47:0] dest_now;
  logic [63:0] hdr_tail;
  logic        dest_ok;
  logic        len_ok;
  logic        crc_ok;

  eth_crc32_d8 u_crc (
    .crc_in  (crc_reg),
    .data    (rxd),
    .crc_out (crc_next)
  );

  // The length counter saturates one past the maximum so an oversize frame
  // stays flagged however long it runs.
  assign len_next = (len_reg == LEN_SAT) ? LEN_SAT : len_reg + 11'd1;
  assign hdr_tail = {hdr_sr_reg, rxd};
  assign dest_now = {hdr_sr_reg[39:0], rxd};
  assign dest_ok  = !CHECK_MAC || (dest_now == local_mac) || (dest_now == BCAST_MAC);
  assign len_ok   = (len_reg >= LEN_MIN) && (len_reg <= LEN_MAX);
  assign crc_ok   = (crc_reg == CRC_RESIDUE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      pre_cnt_reg   <= '0;
      len_reg       <= '0;
      crc_reg       <= '0;
      hdr_sr_reg    <= '0;
      dline_reg     <= '0;
      dfill_reg     <= '0;
      sof_pend_reg  <= 1'b0;
      payload_valid <= 1'b0;
      payload_data  <= '0;
      payload_sof   <= 1'b0;
      payload_eof   <= 1'b0;
      frame_done    <= 1'b0;
      frame_good    <= 1'b0;
      src_mac       <= '0;
      eth_type      <= '0;
      good_cnt      <= '0;
      err_cnt       <= '0;
    end else begin
      payload_valid <= 1'b0;
      payload_sof   <= 1'b0;
      payload_eof   <= 1'b0;
      frame_done    <= 1'b0;
      frame_good    <= 1'b0;
      case (state_reg)
        // END shares the start-of-frame decode so back-to-back bytes are not lost.
        IDLE, END: begin
          if (rx_dv) begin
            if (rxd == PREAMBLE_BYTE) begin
              state_reg   <= PRE;
              pre_cnt_reg <= 3'd1;
            end else begin
              state_reg <= DROP;
              err_cnt   <= err_cnt + 16'd1;
            end
          end else begin
            state_reg <= IDLE;
          end
        end
        PRE: begin
          if (!rx_dv) begin
            state_reg <= IDLE;
          end else if (rxd == PREAMBLE_BYTE) begin
            if (pre_cnt_reg == 3'd7) begin
              state_reg <= DROP;
              err_cnt   <= err_cnt + 16'd1;
            end else begin
              pre_cnt_reg <= pre_cnt_reg + 3'd1;
            end
          end else if (rxd == SFD_BYTE) begin
            state_reg <= HDR;
            crc_reg   <= CRC_INIT;
            len_reg   <= '0;
          end else begin
            state_reg <= DROP;
            err_cnt   <= err_cnt + 16'd1;
          end
        end
        HDR: begin
          if (!rx_dv) begin
            state_reg   <= END;
            frame_done  <= 1'b1;
            payload_eof <= 1'b1;
            err_cnt     <= err_cnt + 16'd1;
          end else begin
            crc_reg    <= crc_next;
            len_reg    <= len_next;
            hdr_sr_reg <= hdr_tail[55:0];
            if (len_reg == DEST_LAST && !dest_ok) begin
              state_reg <= DROP;
            end else if (len_reg == HDR_LAST) begin
              src_mac      <= hdr_tail[63:16];
              eth_type     <= hdr_tail[15:0];
              state_reg    <= PAY;
              dfill_reg    <= '0;
              sof_pend_reg <= 1'b1;
            end
          end
        end
        PAY: begin
          if (!rx_dv) begin
            state_reg   <= END;
            frame_done  <= 1'b1;
            payload_eof <= 1'b1;
            if (crc_ok && len_ok) begin
              frame_good <= 1'b1;
              good_cnt   <= good_cnt + 16'd1;
            end else begin
              err_cnt <= err_cnt + 16'd1;
            end
          end else begin
            crc_reg   <= crc_next;
            len_reg   <= len_next;
            dline_reg <= {dline_reg[FCS_BYTES-2:0], rxd};
            // The newest four bytes are always withheld: they may be the FCS.
            if (dfill_reg != LINE_FULL) begin
              dfill_reg <= dfill_reg + 3'd1;
            end else if (len_next != LEN_SAT) begin
              payload_valid <= 1'b1;
              payload_data  <= dline_reg[FCS_BYTES-1];
              payload_sof   <= sof_pend_reg;
              sof_pend_reg  <= 1'b0;
            end
          end
        end
        DROP: begin
          if (!rx_dv) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_frame_parser.sv
// Directed bench for eth_rx_frame_parser: a frame-level model predicts payload
// bytes, verdicts and counters; a negedge process compares every cycle.
module tb_eth_rx_frame_parser;

  localparam int          MINF  = 64;
  localparam int          MAXF  = 1518;
  localparam logic [47:0] LMAC  = 48'h000A_3501_0203;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_dv = 1'b0;
  logic [7:0] rxd = 8'h00;

  logic pv, ps, pe, fd, fg;
  logic [7:0] pd;
  logic [47:0] sm;
  logic [15:0] et, gc, ec;
  logic pv_p, ps_p, pe_p, fd_p, fg_p;
  logic [7:0] pd_p;
  logic [47:0] sm_p;
  logic [15:0] et_p, gc_p, ec_p;

  always #5 clk = ~clk;

  eth_rx_frame_parser #(.MIN_FRAME(MINF), .MAX_FRAME(MAXF), .CHECK_MAC(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rxd(rxd), .local_mac(LMAC),
    .payload_valid(pv), .payload_data(pd), .payload_sof(ps), .payload_eof(pe),
    .frame_done(fd), .frame_good(fg), .src_mac(sm), .eth_type(et),
    .good_cnt(gc), .err_cnt(ec)
  );

  eth_rx_frame_parser #(.MIN_FRAME(MINF), .MAX_FRAME(MAXF), .CHECK_MAC(1'b0)) dut_p (
    .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rxd(rxd), .local_mac(LMAC),
    .payload_valid(pv_p), .payload_data(pd_p), .payload_sof(ps_p), .payload_eof(pe_p),
    .frame_done(fd_p), .frame_good(fg_p), .src_mac(sm_p), .eth_type(et_p),
    .good_cnt(gc_p), .err_cnt(ec_p)
  );

  typedef struct {
    logic [7:0] data;
    bit         sof;
  } pexp_t;

  typedef struct {
    bit          good;
    logic [47:0] src;
    logic [15:0] typ;
    int          gcnt;
    int          ecnt;
  } fexp_t;

  int checks = 0;
  int failures = 0;
  logic [7:0] burst[$];
  pexp_t exp_pay[$];
  fexp_t exp_frm[$];
  int m_good[2], m_err[2], m_last_pay[2], m_last_done[2];
  logic [47:0] m_src[2];
  logic [15:0] m_typ[2];
  int seen_pay[2], seen_done[2];
  bit model_en = 1'b1;
  int cyc = 0;
  int drop_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc32(input logic [7:0] b[$], input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Builds preamble + SFD + frame of flen bytes (dest through FCS).
  task automatic build(input int npre, input logic [47:0] dst, input int flen,
                       input int seed, input bit flip);
    logic [7:0] fr[$];
    logic [31:0] f;
    logic [47:0] src;
    src = {40'h02_1122_3344, seed[7:0]};
    burst.delete();
    for (int i = 0; i < npre; i++) burst.push_back(8'h55);
    burst.push_back(8'hD5);
    for (int i = 0; i < 6; i++) fr.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) fr.push_back(src[47-8*i -: 8]);
    fr.push_back(8'h08);
    fr.push_back(seed[7:0]);
    for (int i = 14; i < flen - 4; i++) fr.push_back(8'(i * 7 + seed));
    f = crc32(fr, fr.size());
    if (flip) f = f ^ 32'h0000_0100;
    fr.push_back(f[7:0]);
    fr.push_back(f[15:8]);
    fr.push_back(f[23:16]);
    fr.push_back(f[31:24]);
    foreach (fr[i]) burst.push_back(fr[i]);
  endtask

  // Frame-level interpretation of one rx_dv burst.
  task automatic model_burst(input int inst, input bit chkmac);
    logic [7:0] fr[$];
    int n, k, len, np;
    bit good;
    logic [47:0] dst;
    logic [31:0] f;
    pexp_t pe_;
    fexp_t fe;
    n = burst.size();
    k = 0;
    m_last_pay[inst] = 0;
    m_last_done[inst] = 0;
    while (k < n && k < 8 && burst[k] == 8'h55) k++;
    if (k == 0 || k == 8) begin
      m_err[inst]++;
      return;
    end
    if (k == n) return;
    if (burst[k] != 8'hD5) begin
      m_err[inst]++;
      return;
    end
    for (int i = k + 1; i < n; i++) fr.push_back(burst[i]);
    len = fr.size();
    if (len >= 6) begin
      dst = {fr[0], fr[1], fr[2], fr[3], fr[4], fr[5]};
      if (chkmac && dst != LMAC && dst != BCAST) return;
    end
    if (len >= 14) begin
      m_src[inst] = {fr[6], fr[7], fr[8], fr[9], fr[10], fr[11]};
      m_typ[inst] = {fr[12], fr[13]};
    end
    good = (len >= MINF) && (len <= MAXF);
    if (good) begin
      f = crc32(fr, len - 4);
      good = ({fr[len-1], fr[len-2], fr[len-3], fr[len-4]} == f);
    end
    np = (len > 18) ? len - 18 : 0;
    if (np > MAXF - 18) np = MAXF - 18;
    if (good) m_good[inst]++;
    else m_err[inst]++;
    m_last_pay[inst] = np;
    m_last_done[inst] = 1;
    if (inst == 0) begin
      for (int j = 0; j < np; j++) begin
        pe_.data = fr[14+j];
        pe_.sof = (j == 0);
        exp_pay.push_back(pe_);
      end
      fe.good = good;
      fe.src = m_src[0];
      fe.typ = m_typ[0];
      fe.gcnt = m_good[0];
      fe.ecnt = m_err[0];
      exp_frm.push_back(fe);
    end
  endtask

  always @(negedge clk) begin
    pexp_t e;
    fexp_t f;
    if (rst_n && model_en) begin
      if (pv) begin
        seen_pay[0]++;
        if (exp_pay.size() == 0) begin
          chk("unexpected_payload", 64'(pd), 64'hFFFF);
        end else begin
          e = exp_pay.pop_front();
          chk("payload_data", 64'(pd), 64'(e.data));
          chk("payload_sof", 64'(ps), 64'(e.sof));
        end
      end else begin
        chk("sof_without_valid", 64'(ps), 64'd0);
      end
      chk("eof_with_done", 64'(pe), 64'(fd));
      if (fd) begin
        seen_done[0]++;
        if (exp_frm.size() == 0) begin
          chk("unexpected_frame_done", 64'(fd), 64'd0);
        end else begin
          f = exp_frm.pop_front();
          chk("frame_good", 64'(fg), 64'(f.good));
          chk("src_mac", 64'(sm), 64'(f.src));
          chk("eth_type", 64'(et), 64'(f.typ));
          chk("good_cnt_at_done", 64'(gc), 64'(16'(f.gcnt)));
          chk("err_cnt_at_done", 64'(ec), 64'(16'(f.ecnt)));
          chk("done_latency", 64'(cyc), 64'(drop_cyc + 1));
        end
      end
      if (pv_p) seen_pay[1]++;
      if (fd_p) seen_done[1]++;
    end else if (rst_n) begin
      chk("no_done_abandoned", 64'(fd | fd_p), 64'd0);
    end
  end

  task automatic drive_burst();
    for (int i = 0; i < burst.size(); i++) begin
      @(posedge clk); #1;
      rx_dv = 1'b1;
      rxd = burst[i];
    end
    @(posedge clk); #1;
    rx_dv = 1'b0;
    rxd = 8'h00;
    drop_cyc = cyc;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic run(input string name, input int lit_pay, input int lit_done);
    int p0, d0, p1, d1;
    p0 = seen_pay[0];
    d0 = seen_done[0];
    p1 = seen_pay[1];
    d1 = seen_done[1];
    model_burst(0, 1'b1);
    model_burst(1, 1'b0);
    drive_burst();
    chk({name, "_pay_count"}, 64'(seen_pay[0] - p0), 64'(lit_pay));
    chk({name, "_done_count"}, 64'(seen_done[0] - d0), 64'(lit_done));
    chk({name, "_good_cnt"}, 64'(gc), 64'(16'(m_good[0])));
    chk({name, "_err_cnt"}, 64'(ec), 64'(16'(m_err[0])));
    chk({name, "_prom_pay_count"}, 64'(seen_pay[1] - p1), 64'(m_last_pay[1]));
    chk({name, "_prom_done_count"}, 64'(seen_done[1] - d1), 64'(m_last_done[1]));
    chk({name, "_prom_good_cnt"}, 64'(gc_p), 64'(16'(m_good[1])));
    chk({name, "_prom_err_cnt"}, 64'(ec_p), 64'(16'(m_err[1])));
    chk({name, "_queues_drained"}, 64'(exp_pay.size() + exp_frm.size()), 64'd0);
    $display("txn %s: payload=%0d done=%0d good_cnt=%0d err_cnt=%0d prom_good=%0d prom_err=%0d",
             name, seen_pay[0] - p0, seen_done[0] - d0, gc, ec, gc_p, ec_p);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_payload_valid"}, 64'(pv), 64'd0);
    chk({tag, "_payload_data"}, 64'(pd), 64'd0);
    chk({tag, "_payload_sof"}, 64'(ps), 64'd0);
    chk({tag, "_payload_eof"}, 64'(pe), 64'd0);
    chk({tag, "_frame_done"}, 64'(fd), 64'd0);
    chk({tag, "_frame_good"}, 64'(fg), 64'd0);
    chk({tag, "_src_mac"}, 64'(sm), 64'd0);
    chk({tag, "_eth_type"}, 64'(et), 64'd0);
    chk({tag, "_good_cnt"}, 64'(gc), 64'd0);
    chk({tag, "_err_cnt"}, 64'(ec), 64'd0);
    chk({tag, "_prom_good_cnt"}, 64'(gc_p), 64'd0);
    chk({tag, "_prom_err_cnt"}, 64'(ec_p), 64'd0);
    chk({tag, "_prom_valid"}, 64'(pv_p), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got still running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_zero("post_reset");

    build(7, LMAC, 64, 1, 1'b0);                     run("good_local", 46, 1);
    chk("good_local_literal_good_cnt", 64'(gc), 64'd1);
    build(7, BCAST, 64, 2, 1'b0);                    run("broadcast", 46, 1);
    build(7, 48'h0200_0000_0099, 64, 3, 1'b0);       run("foreign_dest", 0, 0);
    build(7, LMAC, 64, 4, 1'b1);                     run("fcs_flip", 46, 1);
    chk("fcs_flip_literal_err_cnt", 64'(ec), 64'd1);
    build(7, LMAC, 60, 5, 1'b0);                     run("runt60", 42, 1);
    build(7, LMAC, 1518, 6, 1'b0);                   run("max1518", 1500, 1);
    build(7, LMAC, 1519, 7, 1'b0);                   run("long1519", 1500, 1);
    build(1, LMAC, 64, 8, 1'b0);
    burst.insert(1, 8'h57);                          run("preamble_57", 0, 0);
    build(8, LMAC, 64, 9, 1'b0);                     run("preamble_8x55", 0, 0);
    build(7, LMAC, 64, 10, 1'b0);
    burst = burst[0:17];                             run("hdr_abort", 0, 1);
    build(1, LMAC, 64, 11, 1'b0);                    run("preamble_1x55", 46, 1);
    chk("literal_err_cnt_before_reset", 64'(ec), 64'd6);

    // Reset while payload byte 20 is on the wire, then a frame straight after.
    model_en = 1'b0;
    build(7, LMAC, 64, 12, 1'b0);
    for (int i = 0; i <= 8 + 14 + 20; i++) begin
      @(posedge clk); #1;
      rx_dv = 1'b1;
      rxd = burst[i];
    end
    #2;
    rst_n = 1'b0;
    rx_dv = 1'b0;
    rxd = 8'h00;
    #1;
    chk_zero("mid_frame_reset");
    repeat (2) @(posedge clk);
    #1;
    chk_zero("held_reset");
    rst_n = 1'b1;
    exp_pay.delete();
    exp_frm.delete();
    for (int i = 0; i < 2; i++) begin
      m_good[i] = 0;
      m_err[i] = 0;
      m_src[i] = '0;
      m_typ[i] = '0;
      seen_pay[i] = 0;
      seen_done[i] = 0;
    end
    model_en = 1'b1;
    build(7, LMAC, 64, 13, 1'b0);                    run("after_reset", 46, 1);
    chk("after_reset_literal_good_cnt", 64'(gc), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
